// File: rtl/ysyx_25040129_wb_arbiter.sv
// Write-back arbiter: shares the single GPR write port and the single CSR
// write port between the LSU path (port 0) and the EXU fast path (port 1).
// One grant per cycle. Port 0 normally wins ties. A starvation counter hands
// the tie-break to port 1 after it has been refused STARVE_LIMIT times in a row.
// The winning request is registered and drives the register files one cycle
// after its handshake.
module ysyx_25040129_wb_arbiter #(
    parameter int REGS_DIG     = 5,
    parameter int CSR_DIG      = 12,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wb_stall,

    input  logic                p0_valid,
    output logic                p0_ready,
    input  logic [REGS_DIG-1:0] p0_rd,
    input  logic [31:0]         p0_result,
    input  logic                p0_reg_write,
    input  logic                p0_csr_write,
    input  logic [CSR_DIG-1:0]  p0_csr_addr,
    input  logic [31:0]         p0_csr_data,

    input  logic                p1_valid,
    output logic                p1_ready,
    input  logic [REGS_DIG-1:0] p1_rd,
    input  logic [31:0]         p1_result,
    input  logic                p1_reg_write,
    input  logic                p1_csr_write,
    input  logic [CSR_DIG-1:0]  p1_csr_addr,
    input  logic [31:0]         p1_csr_data,

    output logic                rf_wen,
    output logic [REGS_DIG-1:0] rf_waddr,
    output logic [31:0]         rf_wdata,
    output logic                csr_wen,
    output logic [CSR_DIG-1:0]  csr_waddr,
    output logic [31:0]         csr_wdata,
    output logic                retire,
    output logic                retire_src
);

    typedef struct packed {
        logic [REGS_DIG-1:0] rd;
        logic [31:0]         result;
        logic                reg_write;
        logic                csr_write;
        logic [CSR_DIG-1:0]  csr_addr;
        logic [31:0]         csr_data;
    } wb_req_t;

    localparam logic [0:0] PRI0 = 1'b0;  // port 0 wins ties
    localparam logic [0:0] PRI1 = 1'b1;  // port 1 wins ties

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    wb_req_t req0, req1, win;
    logic    hs0, hs1, hs, p1_inc;

    assign req0 = '{rd: p0_rd, result: p0_result, reg_write: p0_reg_write,
                    csr_write: p0_csr_write, csr_addr: p0_csr_addr, csr_data: p0_csr_data};
    assign req1 = '{rd: p1_rd, result: p1_result, reg_write: p1_reg_write,
                    csr_write: p1_csr_write, csr_addr: p1_csr_addr, csr_data: p1_csr_data};

    // Grant: the priority state breaks ties; a stall suppresses both readies.
    always_comb begin
        p0_ready = 1'b0;
        p1_ready = 1'b0;
        if (!wb_stall) begin
            if (state_q == PRI0) begin
                p0_ready = p0_valid;
                p1_ready = p1_valid & ~p0_valid;
            end else begin
                p1_ready = p1_valid;
                p0_ready = p0_valid & ~p1_valid;
            end
        end
    end

    assign hs0    = p0_valid & p0_ready;
    assign hs1    = p1_valid & p1_ready;
    assign hs     = hs0 | hs1;
    // Port 1 waited and was turned away this cycle, and the counter has room.
    assign p1_inc = p1_valid & ~p1_ready & ~wb_stall & (cnt_q != CNT_MAX);
    assign win    = hs1 ? req1 : req0;

    // Starvation counter and priority state next-state.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (hs1)
            cnt_d = '0;
        else if (p1_inc)
            cnt_d = cnt_q + 1'b1;
        case (state_q)
            PRI0:    if (p1_inc && cnt_q == LIMIT_M1) state_d = PRI1;
            PRI1:    if (hs1) state_d = PRI0;
            default: state_d = PRI0;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= PRI0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output stage: register the winner; strobes drop when nothing is accepted,
    // addresses and data keep their last value.
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_wen     <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            csr_wen    <= 1'b0;
            csr_waddr  <= '0;
            csr_wdata  <= '0;
            retire     <= 1'b0;
            retire_src <= 1'b0;
        end else if (hs) begin
            rf_wen     <= win.reg_write & (win.rd != '0);
            rf_waddr   <= win.rd;
            rf_wdata   <= win.result;
            csr_wen    <= win.csr_write;
            csr_waddr  <= win.csr_addr;
            csr_wdata  <= win.csr_data;
            retire     <= 1'b1;
            retire_src <= hs1;
        end else begin
            rf_wen     <= 1'b0;
            csr_wen    <= 1'b0;
            retire     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_25040129_wb_arbiter.sv
// Bench for the write-back arbiter: directed scenarios plus random traffic,
// every cycle checked against a behavioural model of the arbitration rules.
module tb_ysyx_25040129_wb_arbiter;

    localparam int LIMIT = 4;
    localparam int CNTW  = 3;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
        bit          rw;
        bit          cw;
        logic [11:0] ca;
        logic [31:0] cd;
    } req_t;

    logic clock = 1'b0, reset = 1'b1, wb_stall = 1'b0;
    logic p0_valid = 1'b0, p0_reg_write = 1'b0, p0_csr_write = 1'b0;
    logic p1_valid = 1'b0, p1_reg_write = 1'b0, p1_csr_write = 1'b0;
    logic [4:0]  p0_rd = '0, p1_rd = '0;
    logic [31:0] p0_result = '0, p1_result = '0, p0_csr_data = '0, p1_csr_data = '0;
    logic [11:0] p0_csr_addr = '0, p1_csr_addr = '0;
    logic p0_ready, p1_ready, rf_wen, csr_wen, retire, retire_src;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, csr_wdata;
    logic [11:0] csr_waddr;

    ysyx_25040129_wb_arbiter #(.REGS_DIG(5), .CSR_DIG(12), .STARVE_LIMIT(LIMIT), .CNT_W(CNTW)) dut (
        .clock(clock), .reset(reset), .wb_stall(wb_stall),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_rd(p0_rd), .p0_result(p0_result),
        .p0_reg_write(p0_reg_write), .p0_csr_write(p0_csr_write),
        .p0_csr_addr(p0_csr_addr), .p0_csr_data(p0_csr_data),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_rd(p1_rd), .p1_result(p1_result),
        .p1_reg_write(p1_reg_write), .p1_csr_write(p1_csr_write),
        .p1_csr_addr(p1_csr_addr), .p1_csr_data(p1_csr_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .retire(retire), .retire_src(retire_src));

    always #5 clock = ~clock;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: "owed" means port 1 has been refused enough times in a
    // row that it now wins the next tie; "refused" counts those refusals.
    bit          m_owed = 0;
    int          m_refused = 0;
    bit          e_rfw = 0, e_cw = 0, e_ret = 0, e_src = 0;
    logic [4:0]  e_wa = '0;
    logic [31:0] e_wd = '0, e_cd = '0;
    logic [11:0] e_ca = '0;
    bit          last_g1;

    function automatic req_t rnd_req();
        req_t r;
        r.rd  = 5'($urandom_range(0, 31));
        r.res = $urandom;
        r.rw  = 1'($urandom);
        r.cw  = ($urandom_range(0, 3) == 0);
        r.ca  = 12'($urandom);
        r.cd  = $urandom;
        return r;
    endfunction

    // One clock cycle: drive, check readies, clock, update model, check outputs.
    task automatic cyc(input bit rst, input bit stall, input bit v0, input req_t r0,
                       input bit v1, input req_t r1);
        bit g0, g1;
        req_t w;
        @(negedge clock);
        reset = rst; wb_stall = stall;
        p0_valid = v0; p0_rd = r0.rd; p0_result = r0.res; p0_reg_write = r0.rw;
        p0_csr_write = r0.cw; p0_csr_addr = r0.ca; p0_csr_data = r0.cd;
        p1_valid = v1; p1_rd = r1.rd; p1_result = r1.res; p1_reg_write = r1.rw;
        p1_csr_write = r1.cw; p1_csr_addr = r1.ca; p1_csr_data = r1.cd;
        g0 = 0; g1 = 0;
        if (!stall) begin
            if (v0 && v1) begin g1 = m_owed; g0 = !m_owed; end
            else begin g0 = v0; g1 = v1; end
        end
        last_g1 = g1;
        #1;
        if (!rst) begin
            chk("p0_ready", p0_ready, g0);
            chk("p1_ready", p1_ready, g1);
        end
        @(posedge clock);
        if (rst) begin
            m_owed = 0; m_refused = 0;
            e_rfw = 0; e_cw = 0; e_ret = 0; e_src = 0;
            e_wa = '0; e_wd = '0; e_ca = '0; e_cd = '0;
        end else begin
            if (g0 || g1) begin
                w = g1 ? r1 : r0;
                e_rfw = w.rw && (w.rd != 0); e_wa = w.rd; e_wd = w.res;
                e_cw = w.cw; e_ca = w.ca; e_cd = w.cd;
                e_ret = 1; e_src = g1;
            end else begin
                e_rfw = 0; e_cw = 0; e_ret = 0;
            end
            if (g1) begin
                m_refused = 0; m_owed = 0;
            end else if (!stall && v1 && m_refused < (1 << CNTW) - 1) begin
                if (m_refused == LIMIT - 1) m_owed = 1;
                m_refused++;
            end
        end
        #1;
        chk("rf_wen", rf_wen, e_rfw);
        chk("rf_waddr", rf_waddr, e_wa);
        chk("rf_wdata", rf_wdata, e_wd);
        chk("csr_wen", csr_wen, e_cw);
        chk("csr_waddr", csr_waddr, e_ca);
        chk("csr_wdata", csr_wdata, e_cd);
        chk("retire", retire, e_ret);
        if (e_ret) chk("retire_src", retire_src, e_src);
    endtask

    initial begin
        req_t a, b;
        int k;
        a = rnd_req(); b = rnd_req();

        // Reset with both ports valid; outputs must stay clear.
        cyc(1, 0, 1, a, 1, b);
        cyc(1, 0, 1, a, 1, b);

        // Continuous contention: port 1 gets every fifth grant.
        for (int i = 0; i < 15; i++) begin
            cyc(0, 0, 1, rnd_req(), 1, rnd_req());
            chk("starve_pattern", last_g1, (i % 5) == 4);
        end

        // p0 alone writes x5.
        a = '{rd: 5'd5, res: 32'hDEADBEEF, rw: 1, cw: 0, ca: 12'h0, cd: 32'h0};
        cyc(0, 0, 1, a, 0, b);
        chk("p0_x5_wdata", rf_wdata, 64'hDEADBEEF);
        chk("p0_x5_src", retire_src, 0);

        // p1 csrrw to x0: CSR strobes, GPR does not, still retires.
        b = '{rd: 5'd0, res: 32'h1234, rw: 1, cw: 1, ca: 12'h305, cd: 32'h80000000};
        cyc(0, 0, 0, a, 1, b);
        chk("csrrw_csr_wen", csr_wen, 1);
        chk("csrrw_rf_wen", rf_wen, 0);
        chk("csrrw_retire", retire, 1);

        // Stall in the middle of a contention run: order resumes where it stopped.
        cyc(1, 0, 0, a, 0, b);
        k = 0;
        for (int i = 0; i < 16; i++) begin
            bit st;
            st = (i >= 2 && i < 8);
            cyc(0, st, 1, rnd_req(), 1, rnd_req());
            if (st) chk("stall_no_grant", last_g1, 0);
            else begin
                chk("stall_pattern", last_g1, (k % 5) == 4);
                k++;
            end
        end

        // Handshake then reset on the next edge: the registered write is dropped.
        cyc(0, 0, 1, rnd_req(), 1, rnd_req());
        cyc(1, 0, 1, rnd_req(), 1, rnd_req());
        chk("rst_drop_retire", retire, 0);
        cyc(0, 0, 1, rnd_req(), 1, rnd_req());
        chk("rst_pri0_src", retire_src, 0);

        // Random traffic with occasional stalls and resets.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) != 0), rnd_req(),
                ($urandom_range(0, 2) != 0), rnd_req());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
